// File: rtl/pseudo_softmax_pkg.sv
// Shared definitions for the pseudo-softmax datapath: default widths, the
// Q-format unit constant and the control FSM encoding.
package pseudo_softmax_pkg;

   localparam int NUM_INPUTS = 10;
   localparam int EXP_WIDTH  = 9;
   localparam int MANT_WIDTH = 8;
   localparam int ONE        = 1 << MANT_WIDTH;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/log2_domain_divide.sv
// Combinational 2^x / sum in the log2 domain (Mitchell approximation).
// Saturates when the quotient reaches 1 and flushes to zero on deep underflow.
module log2_domain_divide #(
   parameter int EXP_WIDTH  = 9,
   parameter int MANT_WIDTH = 8
) (
   input  logic [MANT_WIDTH-1:0] x,
   input  logic [EXP_WIDTH-1:0]  e,
   input  logic [MANT_WIDTH-1:0] m,
   output logic [MANT_WIDTH-1:0] p
);

   localparam int F  = MANT_WIDTH;
   localparam int DW = EXP_WIDTH + MANT_WIDTH + 2;

   logic signed [DW-1:0] d;
   logic signed [DW-1:0] int_part;
   logic [F-1:0]         frac;
   logic [DW-1:0]        shift;

   always_comb begin
      // Two guard bits keep the most negative difference (x=0, E and M maximal) in range.
      d        = $signed({{(DW-2*F){1'b0}}, x, {F{1'b0}}}) - $signed({2'b00, e, m});
      int_part = d >>> F;
      frac     = d[F-1:0];
      shift    = -int_part;
      if (!int_part[DW-1]) begin
         p = '1;
      end else if (shift > DW'(F)) begin
         p = '0;
      end else begin
         p = F'({1'b1, frac} >> shift);
      end
   end

endmodule

// File: rtl/pseudo_softmax_normalizer_seq.sv
// Captures one exponent vector plus its float sum and streams the normalized
// probabilities one element per output handshake.
module pseudo_softmax_normalizer_seq #(
   parameter int NUM_INPUTS = pseudo_softmax_pkg::NUM_INPUTS,
   parameter int EXP_WIDTH  = pseudo_softmax_pkg::EXP_WIDTH,
   parameter int MANT_WIDTH = pseudo_softmax_pkg::MANT_WIDTH,
   parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus,
   input  logic [EXP_WIDTH-1:0]             exp,
   input  logic [MANT_WIDTH-1:0]            mant,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [MANT_WIDTH-1:0]            out_data,
   output logic [IDX_WIDTH-1:0]             out_index,
   output logic                             out_last
);

   import pseudo_softmax_pkg::*;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

   state_t                state_reg, state_next;
   logic [MANT_WIDTH-1:0] in_vec  [NUM_INPUTS];
   logic [MANT_WIDTH-1:0] vec_reg [NUM_INPUTS];
   logic [EXP_WIDTH-1:0]  e_reg;
   logic [MANT_WIDTH-1:0] m_reg;
   logic [IDX_WIDTH-1:0]  idx_reg, idx_next, sel_idx;
   logic [MANT_WIDTH-1:0] data_reg, data_next;
   logic                  last_reg, last_next;
   logic                  accept;
   logic [MANT_WIDTH-1:0] div_x, div_m, div_p;
   logic [EXP_WIDTH-1:0]  div_e;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
         assign in_vec[gi] = input_bus[gi*MANT_WIDTH +: MANT_WIDTH];
      end
   endgenerate

   assign accept  = (state_reg == IDLE) && in_valid;
   assign sel_idx = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

   // While idle the divider sees the live ports so element 0 is ready at accept.
   always_comb begin
      if (state_reg == IDLE) begin
         div_x = in_vec[0];
         div_e = exp;
         div_m = mant;
      end else begin
         div_x = vec_reg[sel_idx];
         div_e = e_reg;
         div_m = m_reg;
      end
   end

   log2_domain_divide #(
      .EXP_WIDTH  (EXP_WIDTH),
      .MANT_WIDTH (MANT_WIDTH)
   ) u_divide (
      .x (div_x),
      .e (div_e),
      .m (div_m),
      .p (div_p)
   );

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      data_next  = data_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = EMIT;
               idx_next   = '0;
               data_next  = div_p;
               last_next  = 1'b0;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (last_reg) begin
                  state_next = IDLE;
                  idx_next   = '0;
                  data_next  = '0;
                  last_next  = 1'b0;
               end else begin
                  idx_next  = sel_idx;
                  data_next = div_p;
                  last_next = (sel_idx == LAST_IDX);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         data_reg  <= '0;
         last_reg  <= 1'b0;
         e_reg     <= '0;
         m_reg     <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) vec_reg[i] <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         data_reg  <= data_next;
         last_reg  <= last_next;
         if (accept) begin
            e_reg <= exp;
            m_reg <= mant;
            for (int i = 0; i < NUM_INPUTS; i++) vec_reg[i] <= in_vec[i];
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == EMIT);
   assign out_data  = data_reg;
   assign out_index = idx_reg;
   assign out_last  = last_reg;

endmodule

// File: tb/tb_pseudo_softmax_normalizer_seq.sv
// Randomized and directed bench for pseudo_softmax_normalizer_seq against a
// plain-arithmetic model of the log2-domain division and the beat stream.
module tb_pseudo_softmax_normalizer_seq;

   localparam int N    = 10;
   localparam int EW   = 9;
   localparam int F    = 8;
   localparam int IW   = $clog2(N);
   localparam int BUSW = N * F;

   typedef struct {
      int data;
      int idx;
      int last;
   } beat_t;

   typedef int lit_t [N];

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [BUSW-1:0] input_bus = '0;
   logic [EW-1:0]   exp_in = '0;
   logic [F-1:0]    mant_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [F-1:0]    out_data;
   logic [IW-1:0]   out_index;
   logic            out_last;

   int passed = 0;
   int total  = 0;
   int cyc = 0;
   int last_hs_cyc = -100;
   int accept_cyc = -100;
   int n_accept = 0;
   beat_t q[$];

   pseudo_softmax_normalizer_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .input_bus (input_bus),
      .exp       (exp_in),
      .mant      (mant_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
   endtask

   // p = 2^x / (2^E * (1 + M/2^F)) with log2 and antilog both linear in the fraction
   function automatic int model_f(input int x, input int e, input int m);
      int d, ip, fr;
      d = x * (1 << F) - (e * (1 << F) + m);
      if (d >= 0) return (1 << F) - 1;
      ip = -((-d + (1 << F) - 1) / (1 << F));
      fr = d - ip * (1 << F);
      if (-ip > F) return 0;
      return ((1 << F) + fr) >> (-ip);
   endfunction

   // Compare process: every cycle, against the queue of beats still owed.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         chk("reset_outputs", {out_valid, in_ready, out_last, 4'(out_index), out_data},
             {1'b0, 1'b1, 1'b0, 4'd0, 8'd0});
      end else begin
         chk("in_ready", int'(in_ready), int'(q.size() == 0));
         chk("out_valid", int'(out_valid), int'(q.size() != 0));
         if (q.size() != 0) begin
            chk($sformatf("beat_data[%0d]", q[0].idx), int'(out_data), q[0].data);
            chk("beat_index", int'(out_index), q[0].idx);
            chk($sformatf("beat_last[%0d]", q[0].idx), int'(out_last), q[0].last);
            if (out_ready) begin
               if (q[0].last != 0) last_hs_cyc = cyc;
               void'(q.pop_front());
            end
         end else if (in_valid) begin
            for (int i = 0; i < N; i++) begin
               beat_t b;
               b.data = model_f(int'(input_bus[i*F +: F]), int'(exp_in), int'(mant_in));
               b.idx  = i;
               b.last = (i == N - 1) ? 1 : 0;
               q.push_back(b);
            end
            accept_cyc = cyc;
            n_accept++;
         end
      end
   end

   task automatic send_vec(input logic [BUSW-1:0] bus, input int e, input int m);
      bit ok = 0;
      in_valid  = 1'b1;
      input_bus = bus;
      exp_in    = EW'(e);
      mant_in   = F'(m);
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      input_bus = {$urandom, $urandom, $urandom};
      exp_in    = EW'($urandom);
      mant_in   = F'($urandom);
   endtask

   // Stream one burst with out_ready high, pinning selected beats to literals (-1 = skip).
   task automatic drain_lits(input lit_t lits);
      bit done = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (out_valid) begin
            if (lits[out_index] >= 0)
               chk($sformatf("literal[%0d]", out_index), int'(out_data), lits[out_index]);
            if (out_last) done = 1;
         end
      end
      if (!done) chk("drain_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BUSW-1:0] make_bus(input int x0, input int x1, input int x2, input int rest);
      logic [BUSW-1:0] b;
      for (int i = 0; i < N; i++) b[i*F +: F] = F'(rest + i);
      b[0 +: F]   = F'(x0);
      b[F +: F]   = F'(x1);
      b[2*F +: F] = F'(x2);
      return b;
   endfunction

   initial begin
      lit_t lits;
      logic [BUSW-1:0] bus;
      int e, first_acc;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-burst after three handshakes
      send_vec(make_bus(3, 4, 5, 1), 6, 10);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", int'(out_valid), 0);
      chk("async_rst_out_index", int'(out_index), 0);
      chk("async_rst_in_ready", int'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic: all x=3, E=5, M=0 -> 2^-2 = 64
      for (int i = 0; i < N; i++) lits[i] = 64;
      send_vec({N{8'd3}}, 5, 0);
      drain_lits(lits);

      // Fractional mantissa
      for (int i = 0; i < N; i++) lits[i] = -1;
      lits[0] = 192; lits[1] = 96; lits[2] = 255;
      send_vec(make_bus(5, 4, 6, 0), 5, 128);
      drain_lits(lits);

      // Underflow and extremes
      for (int i = 0; i < N; i++) lits[i] = -1;
      lits[0] = 0;
      send_vec(make_bus(0, 7, 9, 2), 20, 255);
      drain_lits(lits);
      lits[0] = 0; lits[1] = 255; lits[2] = 1;
      send_vec(make_bus(0, 20, 12, 3), 20, 0);
      drain_lits(lits);

      // Sum of exactly 1 and the largest possible sum
      for (int i = 0; i < N; i++) lits[i] = 255;
      send_vec(make_bus(0, 255, 1, 0), 0, 0);
      drain_lits(lits);
      for (int i = 0; i < N; i++) lits[i] = 0;
      send_vec(make_bus(0, 255, 255, 200), 511, 255);
      drain_lits(lits);

      // Randomized traffic with backpressure and in_valid pulses during bursts
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #1;
         e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 30));
         in_valid = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            int xv;
            xv = e + 2 - int'($urandom_range(0, 11));
            if ($urandom_range(0, 5) == 0) xv = int'($urandom_range(0, 255));
            if (xv < 0) xv = 0;
            if (xv > 255) xv = 255;
            input_bus[i*F +: F] = F'(xv);
         end
         exp_in    = EW'(e);
         mant_in   = F'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && out_valid; k++) @(posedge clk);
      #1;
      chk("random_drained", int'(out_valid), 0);

      // Back-to-back vectors with in_valid held high
      first_acc = n_accept;
      in_valid  = 1'b1;
      input_bus = {N{8'd5}};
      exp_in    = EW'(5);
      mant_in   = F'(0);
      for (int k = 0; k < 50 && n_accept == first_acc; k++) @(posedge clk);
      #1;
      bus = make_bus(9, 3, 7, 4);
      input_bus = bus;
      exp_in    = EW'(7);
      mant_in   = F'(64);
      for (int k = 0; k < 100 && n_accept < first_acc + 2; k++) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_accepts", n_accept - first_acc, 2);
      chk("b2b_gap_cycles", accept_cyc - last_hs_cyc, 1);
      for (int k = 0; k < 100 && out_valid; k++) @(posedge clk);
      #1;
      chk("b2b_drained", int'(out_valid), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
